mem_bus_arbiter: RTL

- Sits directly downstream of n64_top's mem_bus controller port.
- Arbitrates between two memory requesters onto the single memory device port: the N64 PI path and the on-board CPU/USB path.
- Grants one transaction at a time with round-robin fairness.
- Registers the outgoing request and the returned read data.

---
 rtl/mem_bus_arbiter_pkg.sv | 18 +
 rtl/mem_bus_arbiter_if.sv | 28 ++
 rtl/mem_bus_rr_select.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        REQ_N64 = 1'b0,
        REQ_CPU = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One memory bus link: a requester (master) issuing transactions to a responder (slave).
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              request;
    logic              ack;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] wdata_mask;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (
        output request, write, address, wdata_mask, wdata,
        input  ack, rdata
    );

    modport slave (
        input  request, write, address, wdata_mask, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/mem_bus_rr_select.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port not granted last.
module mem_bus_rr_select
    import mem_bus_arbiter_pkg::*;
(
    input  logic    req_n64,
    input  logic    req_cpu,
    input  req_id_e last_grant,
    output logic    valid_c,
    output req_id_e grant_c
);

    // Combinational pick
    always_comb begin
        valid_c = req_n64 | req_cpu;
        grant_c = REQ_N64;
        if (req_n64 && req_cpu) begin
            grant_c = (last_grant == REQ_N64) ? REQ_CPU : REQ_N64;
        end else if (req_cpu) begin
            grant_c = REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the N64 and CPU requesters onto one memory port, one transaction at a time.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  n64,
    mem_bus_arbiter_if.slave  cpu,
    mem_bus_arbiter_if.master mem
);

    localparam int unsigned MASK_W = DATA_W / 8;

    state_e            state;
    state_e            state_next;
    req_id_e           last_grant;
    req_id_e           pick_id;
    logic              pick_valid;
    logic              grant_c;
    logic              complete_c;

    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [MASK_W-1:0] sel_mask;
    logic [DATA_W-1:0] sel_wdata;

    mem_bus_rr_select u_rr_select (
        .req_n64    (n64.request),
        .req_cpu    (cpu.request),
        .last_grant (last_grant),
        .valid_c    (pick_valid),
        .grant_c    (pick_id)
    );

    // Payload of whichever port the round-robin pick selects
    always_comb begin
        sel_write   = n64.write;
        sel_address = n64.address;
        sel_mask    = n64.wdata_mask;
        sel_wdata   = n64.wdata;
        if (pick_id == REQ_CPU) begin
            sel_write   = cpu.write;
            sel_address = cpu.address;
            sel_mask    = cpu.wdata_mask;
            sel_wdata   = cpu.wdata;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE always returns to IDLE so requesters can drop after ack
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = MEM;
            MEM:     if (mem.ack)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM control strobes; mem_ack outside MEM is ignored
    always_comb begin
        grant_c    = 1'b0;
        complete_c = 1'b0;
        case (state)
            IDLE:    grant_c    = pick_valid;
            MEM:     complete_c = mem.ack;
            default: ;
        endcase
    end

    // Registered memory request, port acks, read data and fairness pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            mem.request    <= 1'b0;
            mem.write      <= 1'b0;
            mem.address    <= '0;
            mem.wdata_mask <= '0;
            mem.wdata      <= '0;
            n64.ack        <= 1'b0;
            cpu.ack        <= 1'b0;
            n64.rdata      <= '0;
            cpu.rdata      <= '0;
            last_grant     <= REQ_CPU;
        end else begin
            n64.ack <= complete_c && (last_grant == REQ_N64);
            cpu.ack <= complete_c && (last_grant == REQ_CPU);
            if (grant_c) begin
                mem.request    <= 1'b1;
                mem.write      <= sel_write;
                mem.address    <= sel_address;
                mem.wdata_mask <= sel_mask;
                mem.wdata      <= sel_wdata;
                last_grant     <= pick_id;
            end
            if (complete_c) begin
                mem.request <= 1'b0;
                if (last_grant == REQ_N64) begin
                    n64.rdata <= mem.rdata;
                end else begin
                    cpu.rdata <= mem.rdata;
                end
            end
        end
    end

endmodule
